data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
MEM-stage initiator that drives the 32-bit, 256-word synchronous data memory (address/data/rden/wren/q interface). It accepts byte-addressed load/store requests from the pipeline through a valid/ready handshake and returns load data or store completion. It supports byte/halfword/word sizes with sign or zero extension. Sub-word stores use read-modify-write, because the memory has no byte enables.

Parameters:
ADDR_W, 8, memory word-address width; word index = req_addr[ADDR_W+1:2], upper address bits ignored (wrap)
DATA_W, 32, memory word width; fixed at 32 for byte-lane logic

Ports:
clk  in  1  rising-edge clock, shared with memory
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  in  1  load sign-extend enable
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores)
resp_error  out  1  misaligned flag (feature only)
mem_address  out  ADDR_W  to memory address
mem_data  out  32  to memory data
mem_rden  out  1  to memory rden
mem_wren  out  1  to memory wren
mem_q  in  32  from memory q; valid the cycle after mem_rden was high

Behaviour:
- All outputs registered. On rst (async), every output is 0 immediately, state becomes IDLE, and any in-flight op is aborted with no response.
- States: IDLE, RD, CAP, MERGE, WR, RESP.
- A request is accepted at the clock edge where req_valid && req_ready (call that cycle T). All request fields are latched at acceptance. req_ready is 0 in every state except IDLE.
- Word store: T+1 WR (mem_wren=1, mem_address=index, mem_data=wdata). T+2 RESP (resp_valid=1), then IDLE. Latency 2.
- Load: T+1 RD (mem_rden=1). T+2 CAP (sample mem_q, extract lane, extend). T+3 RESP (resp_valid=1, resp_rdata valid). Latency 3.
- Sub-word store: T+1 RD. T+2 MERGE (register mem_q with the new lane replaced). T+3 WR (mem_wren=1, merged word). T+4 RESP. Latency 4.
- Lanes are little-endian: byte k = bits[8k+7:8k] with k=addr[1:0]; halfword = bits[16*addr[1]+15:16*addr[1]].
- Extension: req_signed=1 replicates the lane MSB; otherwise the lane is zero-filled. Word loads are unaffected by req_signed.
- mem_rden and mem_wren are never both high, and each is high for exactly one cycle per access. Both are 0 in IDLE, CAP, MERGE and RESP. mem_address/mem_data hold their last values when idle.
- resp_rdata holds its value until the next RESP; resp_rdata=0 for stores. resp_error=0 unless the feature flags an error.
- In RESP, req_ready=0. IDLE is re-entered next cycle, so back-to-back accepts are spaced by latency+1 cycles.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0) without the feature: the offending low bits are forced to 0 and the access proceeds aligned.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned request makes no memory access. T+1 is RESP with resp_valid=1, resp_error=1, resp_rdata=0; then IDLE.
- Undefined: resp_error is tied to 0 and misaligned addresses are force-aligned as described in Behaviour.

Test Plan:
1. Word store addr 0x00 data 0x00000001, then word load addr 0x00 -> mem_wren pulse at T+1 with mem_address=0, mem_data=1; load resp_valid at T+3 with resp_rdata=0x00000001.
2. Word store 0x11223344 at addr 0x04, then byte store 0xAB at addr 0x05 -> RD at T+1, WR at T+3 with mem_data=0x1122AB44, resp at T+4; word load addr 0x04 returns 0x1122AB44.
3. Word 0x8000F080 at addr 0x08. Byte load addr 0x08 signed -> 0xFFFFFF80; unsigned -> 0x00000080. Half load addr 0x0A signed -> 0xFFFF8000; addr 0x08 unsigned -> 0x0000F080.
4. req_valid held high with two queued word loads -> req_ready low for T+1..T+3; second accepted at T+4; two resp_valid pulses exactly 4 cycles apart.
5. rst asserted during MERGE of a sub-word store -> outputs go to 0 without waiting for clk; mem_wren never pulses; a later load shows the original word unchanged.
6. Word load addr 0x02 -> with MISALIGN_TRAP_EN: resp_error=1 at T+1, mem_rden never high. Without it: mem_address=0 and resp_rdata=word 0 at T+3.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side request/response bus of the MEM-stage data memory controller.
//   master : pipeline (drives requests, receives responses)
//   slave  : data_mem_ctrl
// Signals:
//   req_valid/req_ready       valid/ready handshake, accept when both high
//   req_write                 1 = store, 0 = load
//   req_size                  00 byte, 01 half, 10/11 word
//   req_signed                sign-extend sub-word loads
//   req_addr                  byte address
//   req_wdata                 store data, right-aligned
//   resp_valid                one-cycle completion pulse
//   resp_rdata                extended load data (0 for stores)
//   resp_error                misaligned-access flag (trap build only)
interface data_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage initiator for a 32-bit synchronous data memory without byte
// enables. Accepts byte-addressed loads/stores of byte/half/word size,
// returns extended load data or store completion. Sub-word stores are done
// as read-modify-write.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   : misaligned requests skip memory and respond with resp_error=1
//   undefined : misaligned low address bits are forced to 0 (access aligned)
//
// Ports:
//   clk            rising-edge clock, shared with the memory
//   rst            asynchronous active-high reset
//   bus            request/response interface (slave modport)
//   o_mem_address  memory word address
//   o_mem_data     memory write data
//   o_mem_rden     memory read enable (q valid the following cycle)
//   o_mem_wren     memory write enable
//   i_mem_q        memory read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request (only state with req_ready=1)
// RD    | mem_rden high for load or sub-word store
// CAP   | load: mem_q valid, extract lane and extend into resp_rdata
// MERGE | sub-word store: mem_q valid, replace lane into write word
// WR    | mem_wren high with final word
// RESP  | resp_valid pulse
module data_mem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   data_mem_ctrl_if.slave     bus,
   output logic [ADDR_W-1:0]  o_mem_address,
   output logic [DATA_W-1:0]  o_mem_data,
   output logic               o_mem_rden,
   output logic               o_mem_wren,
   input  logic [DATA_W-1:0]  i_mem_q
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_MERGE,
      S_WR,
      S_RESP
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   // latched request fields
   logic               r_write;
   logic [1:0]         r_size;
   logic               r_signed;
   logic [1:0]         r_lo;
   logic [15:0]        r_wdata;

   // registered outputs
   logic               r_req_ready;
   logic               r_resp_valid;
   logic [31:0]        r_resp_rdata;
   logic               r_resp_error;
   logic [ADDR_W-1:0]  r_mem_address;
   logic [31:0]        r_mem_data;
   logic               r_mem_rden;
   logic               r_mem_wren;

   logic               w_accept;
   logic               w_trap;
   logic [1:0]         w_req_lo;
   logic [ADDR_W-1:0]  w_req_index;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [31:0]        w_load_data;
   logic [31:0]        w_merged;
   logic [ADDR_W-1:0]  w_mem_address_nxt;
   logic [31:0]        w_mem_data_nxt;
   logic [31:0]        w_resp_rdata_nxt;
   logic               w_resp_error_nxt;
   logic               w_unused_addr;

   assign w_accept      = bus.req_valid & r_req_ready & (r_state == S_IDLE);
   assign w_req_index   = bus.req_addr[ADDR_W+1:2];
   // address bits above the word index wrap and are intentionally ignored
   assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                         (bus.req_size[1] & (|bus.req_addr[1:0]));
   assign w_trap       = w_accept & w_misaligned;
`else
   assign w_trap       = 1'b0;
`endif

   // lane offset after forcing misaligned low bits to 0
   always_comb begin
      w_req_lo = 2'b00;
      case (bus.req_size)
         2'b00:   w_req_lo = bus.req_addr[1:0];
         2'b01:   w_req_lo = {bus.req_addr[1], 1'b0};
         default: w_req_lo = 2'b00;
      endcase
   end

   // lane extraction / extension of the word returned by memory
   always_comb begin
      w_byte = i_mem_q[7:0];
      case (r_lo)
         2'd0: w_byte = i_mem_q[7:0];
         2'd1: w_byte = i_mem_q[15:8];
         2'd2: w_byte = i_mem_q[23:16];
         2'd3: w_byte = i_mem_q[31:24];
         default: w_byte = i_mem_q[7:0];
      endcase
      w_half = r_lo[1] ? i_mem_q[31:16] : i_mem_q[15:0];
      case (r_size)
         2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load_data = i_mem_q;
      endcase
   end

   // replace the addressed lane of the old word with the new store data
   always_comb begin
      w_merged = i_mem_q;
      if (r_size == 2'b00) begin
         case (r_lo)
            2'd0: w_merged = {i_mem_q[31:8], r_wdata[7:0]};
            2'd1: w_merged = {i_mem_q[31:16], r_wdata[7:0], i_mem_q[7:0]};
            2'd2: w_merged = {i_mem_q[31:24], r_wdata[7:0], i_mem_q[15:0]};
            2'd3: w_merged = {r_wdata[7:0], i_mem_q[23:0]};
            default: w_merged = i_mem_q;
         endcase
      end else begin
         w_merged = r_lo[1] ? {r_wdata[15:0], i_mem_q[15:0]}
                            : {i_mem_q[31:16], r_wdata[15:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state plus next values of the registered outputs; outputs are
   // registered against the state being entered so they line up with it
   always_comb begin
      w_state_nxt       = r_state;
      w_mem_address_nxt = r_mem_address;
      w_mem_data_nxt    = r_mem_data;
      w_resp_rdata_nxt  = r_resp_rdata;
      w_resp_error_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_trap) begin
                  w_state_nxt      = S_RESP;
                  w_resp_rdata_nxt = 32'd0;
                  w_resp_error_nxt = 1'b1;
               end else begin
                  w_mem_address_nxt = w_req_index;
                  if (bus.req_write && bus.req_size[1]) begin
                     w_state_nxt    = S_WR;
                     w_mem_data_nxt = bus.req_wdata;
                  end else begin
                     w_state_nxt = S_RD;
                  end
               end
            end
         end
         S_RD:    w_state_nxt = r_write ? S_MERGE : S_CAP;
         S_CAP: begin
            w_state_nxt      = S_RESP;
            w_resp_rdata_nxt = w_load_data;
         end
         S_MERGE: begin
            w_state_nxt    = S_WR;
            w_mem_data_nxt = w_merged;
         end
         S_WR: begin
            w_state_nxt      = S_RESP;
            w_resp_rdata_nxt = 32'd0;
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write  <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_lo     <= 2'b00;
         r_wdata  <= 16'd0;
      end else if (w_accept) begin
         r_write  <= bus.req_write;
         r_size   <= bus.req_size;
         r_signed <= bus.req_signed;
         r_lo     <= w_req_lo;
         r_wdata  <= bus.req_wdata[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_ready   <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= 32'd0;
         r_resp_error  <= 1'b0;
         r_mem_address <= '0;
         r_mem_data    <= 32'd0;
         r_mem_rden    <= 1'b0;
         r_mem_wren    <= 1'b0;
      end else begin
         r_req_ready   <= (w_state_nxt == S_IDLE);
         r_resp_valid  <= (w_state_nxt == S_RESP);
         r_resp_rdata  <= w_resp_rdata_nxt;
         r_resp_error  <= w_resp_error_nxt;
         r_mem_address <= w_mem_address_nxt;
         r_mem_data    <= w_mem_data_nxt;
         r_mem_rden    <= (w_state_nxt == S_RD);
         r_mem_wren    <= (w_state_nxt == S_WR);
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_error = r_resp_error;
   assign o_mem_address  = r_mem_address;
   assign o_mem_data     = r_mem_data;
   assign o_mem_rden     = r_mem_rden;
   assign o_mem_wren     = r_mem_wren;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  mem_address;
   logic [31:0] mem_data;
   logic        mem_rden;
   logic        mem_wren;
   logic [31:0] mem_q;

   logic [31:0] mem      [256];
   logic [31:0] init_val [256];
   logic [31:0] mdl_mem  [256];
   bit          init_en;

   int n_cmp;
   int n_bad;

   data_mem_ctrl_if bus ();

   data_mem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .o_mem_address(mem_address),
      .o_mem_data   (mem_data),
      .o_mem_rden   (mem_rden),
      .o_mem_wren   (mem_wren),
      .i_mem_q      (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous 256 x 32 memory, q one cycle after rden
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
      end else begin
         if (mem_wren) mem[mem_address] <= mem_data;
         if (mem_rden) mem_q <= mem[mem_address];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // behavioural reference: expected outcome of one request, updates mdl_mem
   function automatic void model(input bit w, input logic [1:0] sz, input bit sg,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output int lat, output logic [31:0] rd, output bit err,
                                 output int n_rd, output int n_wr,
                                 output int idx, output logic [31:0] wr_word);
      int lo;
      bit mis;
      logic [31:0] old, m, v;
      lo  = (sz == 0) ? int'(a % 4) : (sz == 1) ? int'((a % 4) / 2 * 2) : 0;
      mis = (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
      idx = int'((a / 4) % 256);
      old = mdl_mem[idx];
      rd = 0; err = 0; wr_word = 0;
      if (TRAP && mis) begin
         lat = 1; err = 1; n_rd = 0; n_wr = 0;
      end else if (!w) begin
         lat = 3; n_rd = 1; n_wr = 0;
         if (sz == 0) begin
            v = (old >> (8 * lo)) & 32'hFF;
            if (sg && v >= 128) v = v + 32'hFFFFFF00;
         end else if (sz == 1) begin
            v = (old >> (8 * lo)) & 32'hFFFF;
            if (sg && v >= 32768) v = v + 32'hFFFF0000;
         end else begin
            v = old;
         end
         rd = v;
      end else if (sz >= 2) begin
         lat = 2; n_rd = 0; n_wr = 1;
         wr_word = wd;
         mdl_mem[idx] = wd;
      end else begin
         lat = 4; n_rd = 1; n_wr = 1;
         m = (sz == 0) ? 32'hFF : 32'hFFFF;
         wr_word = (old & ~(m << (8 * lo))) | ((wd & m) << (8 * lo));
         mdl_mem[idx] = wr_word;
      end
   endfunction

   task automatic drive_req(input bit w, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!bus.req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   task automatic do_op(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output bit got_err);
      int lat, n_rd, n_wr, idx, cyc, got_lat, c_rd, c_wr;
      logic [31:0] e_rd, e_wr;
      bit e_err, both, rdy;
      logic [31:0] raddr, waddr, wdat;
      model(w, sz, sg, a, wd, lat, e_rd, e_err, n_rd, n_wr, idx, e_wr);
      @(negedge clk);
      drive_req(w, sz, sg, a, wd);
      wait_ready(tag);
      @(negedge clk);
      bus.req_valid = 1'b0;
      cyc = 1; got_lat = 0; c_rd = 0; c_wr = 0; both = 0; rdy = 0;
      raddr = 0; waddr = 0; wdat = 0; got = 32'hDEADBEEF; got_err = 0;
      while (cyc <= 8) begin
         if (mem_rden) begin c_rd++; raddr = 32'(mem_address); end
         if (mem_wren) begin c_wr++; waddr = 32'(mem_address); wdat = mem_data; end
         if (mem_rden && mem_wren) both = 1;
         if (bus.req_ready) rdy = 1;
         if (bus.resp_valid) begin
            got_lat = cyc;
            got     = bus.resp_rdata;
            got_err = bus.resp_error;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check_val({tag, "_latency"}, 32'(got_lat), 32'(lat));
      check_val({tag, "_rdata"},   got, e_rd);
      check_val({tag, "_error"},   32'(got_err), 32'(e_err));
      check_val({tag, "_n_rden"},  32'(c_rd), 32'(n_rd));
      check_val({tag, "_n_wren"},  32'(c_wr), 32'(n_wr));
      check_val({tag, "_both_en"}, 32'(both), 32'd0);
      check_val({tag, "_busy_ready"}, 32'(rdy), 32'd0);
      if (n_rd > 0) check_val({tag, "_rd_addr"}, raddr, 32'(idx));
      if (n_wr > 0) begin
         check_val({tag, "_wr_addr"}, waddr, 32'(idx));
         check_val({tag, "_wr_data"}, wdat, e_wr);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_ready"},  32'(bus.req_ready), 32'd0);
      check_val({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
      check_val({tag, "_rdata"},  bus.resp_rdata, 32'd0);
      check_val({tag, "_rerr"},   32'(bus.resp_error), 32'd0);
      check_val({tag, "_maddr"},  32'(mem_address), 32'd0);
      check_val({tag, "_mdata"},  mem_data, 32'd0);
      check_val({tag, "_rden"},   32'(mem_rden), 32'd0);
      check_val({tag, "_wren"},   32'(mem_wren), 32'd0);
   endtask

   initial begin
      logic [31:0] got, rd1, rd2, e_rd, e_wr;
      bit          gerr, e_err;
      int          lat, n_rd, n_wr, idx, c_wr, first_ready, resp1, resp2, low_ready;
      int          bad_words;
      logic [1:0]  sz;
      logic [31:0] a;

      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      for (int i = 0; i < 256; i++) begin
         init_val[i] = $urandom;
         mdl_mem[i]  = init_val[i];
      end
      init_en = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      init_en = 1'b0;
      rst = 1'b0;

      // 1: word store then word load
      do_op("t1_sw", 1, 2'b10, 0, 32'h0, 32'h00000001, got, gerr);
      do_op("t1_lw", 0, 2'b10, 0, 32'h0, 32'h0, got, gerr);
      check_val("t1_lw_value", got, 32'h00000001);

      // 2: byte store into a known word
      do_op("t2_sw", 1, 2'b10, 0, 32'h4, 32'h11223344, got, gerr);
      do_op("t2_sb", 1, 2'b00, 0, 32'h5, 32'h000000AB, got, gerr);
      do_op("t2_lw", 0, 2'b10, 0, 32'h4, 32'h0, got, gerr);
      check_val("t2_lw_value", got, 32'h1122AB44);

      // 3: extension cases
      do_op("t3_sw", 1, 2'b10, 0, 32'h8, 32'h8000F080, got, gerr);
      do_op("t3_lbs", 0, 2'b00, 1, 32'h8, 32'h0, got, gerr);
      check_val("t3_lbs_value", got, 32'hFFFFFF80);
      do_op("t3_lbu", 0, 2'b00, 0, 32'h8, 32'h0, got, gerr);
      check_val("t3_lbu_value", got, 32'h00000080);
      do_op("t3_lhs", 0, 2'b01, 1, 32'hA, 32'h0, got, gerr);
      check_val("t3_lhs_value", got, 32'hFFFF8000);
      do_op("t3_lhu", 0, 2'b01, 0, 32'h8, 32'h0, got, gerr);
      check_val("t3_lhu_value", got, 32'h0000F080);

      // 4: back-to-back loads with req_valid held high
      @(negedge clk);
      drive_req(0, 2'b10, 0, 32'h8, 32'h0);
      wait_ready("t4");
      first_ready = 0; resp1 = 0; resp2 = 0; low_ready = 0; rd1 = 0; rd2 = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.req_addr = 32'h4;
         if (c == 5) bus.req_valid = 1'b0;
         if (c <= 3 && !bus.req_ready) low_ready++;
         if (bus.req_ready && first_ready == 0) first_ready = c;
         if (bus.resp_valid && resp1 == 0) begin resp1 = c; rd1 = bus.resp_rdata; end
         else if (bus.resp_valid && resp2 == 0) begin resp2 = c; rd2 = bus.resp_rdata; end
      end
      bus.req_valid = 1'b0;
      check_val("t4_ready_low_cycles", 32'(low_ready), 32'd3);
      check_val("t4_ready_again", 32'(first_ready), 32'd4);
      check_val("t4_resp1_cycle", 32'(resp1), 32'd3);
      check_val("t4_resp_spacing", 32'(resp2 - resp1), 32'd4);
      check_val("t4_rdata1", rd1, mdl_mem[2]);
      check_val("t4_rdata2", rd2, mdl_mem[1]);

      // 5: reset during MERGE of a sub-word store
      @(negedge clk);
      drive_req(1, 2'b00, 0, 32'hC, 32'h0000005A);
      wait_ready("t5");
      @(negedge clk);
      bus.req_valid = 1'b0;
      c_wr = 0;
      if (mem_wren) c_wr++;
      @(negedge clk);
      if (mem_wren) c_wr++;
      #1 rst = 1'b1;
      #1 check_outputs_zero("t5_async");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (mem_wren) c_wr++;
      end
      rst = 1'b0;
      check_val("t5_no_wren", 32'(c_wr), 32'd0);
      do_op("t5_lw", 0, 2'b10, 0, 32'hC, 32'h0, got, gerr);
      check_val("t5_unchanged", got, init_val[3]);

      // 6: misaligned word load
      do_op("t6_lw", 0, 2'b10, 0, 32'h2, 32'h0, got, gerr);
`ifdef MISALIGN_TRAP_EN
      check_val("t6_value", got, 32'h0);
      check_val("t6_err", 32'(gerr), 32'd1);
`else
      check_val("t6_value", got, 32'h00000001);
      check_val("t6_err", 32'(gerr), 32'd0);
`endif

      // randomized traffic over a small window with random wrapping upper bits
      for (int n = 0; n < 200; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
         do_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               a, $urandom, got, gerr);
      end

      // final memory image against the model
      model(0, 2'b10, 0, 32'h0, 32'h0, lat, e_rd, e_err, n_rd, n_wr, idx, e_wr);
      repeat (2) @(negedge clk);
      bad_words = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mdl_mem[i]) bad_words++;
      check_val("final_mem_image", 32'(bad_words), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
